lvds_frame_tx_ctrl: RTL and testbench

LVDS_FRAME_TX_CTRL -- requirements
Module: lvds_frame_tx_ctrl

---
 rtl/lvds_frame_tx_ctrl_if.sv | 27 ++
 rtl/lvds_frame_tx_ctrl.sv | 175 +++++++++++++++++
 tb/tb_lvds_frame_tx_ctrl.sv | 269 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/lvds_frame_tx_ctrl_if.sv
// Bundles the request, payload-source and serializer-side signals of the frame transmitter.
// Latency: none. This file only carries wires and has no storage.
// Backpressure: src_ready from the controller is the only backpressure path toward the source.
interface lvds_frame_tx_ctrl_if;
  logic       start;
  logic       train_req;
  logic [7:0] src_data;
  logic       src_valid;
  logic       src_ready;
  logic [7:0] tx_data;
  logic       tx_en;
  logic       busy;
  logic       frame_done;
  logic       underrun_err;

  // Requester and payload-source side.
  modport master (
    output start, train_req, src_data, src_valid,
    input  src_ready, tx_data, tx_en, busy, frame_done, underrun_err
  );

  // Controller side.
  modport slave (
    input  start, train_req, src_data, src_valid,
    output src_ready, tx_data, tx_en, busy, frame_done, underrun_err
  );
endinterface

// File: rtl/lvds_frame_tx_ctrl.sv
// Frames payload bytes as HEAD0, HEAD1, then PAYLOAD_LEN bytes, then GAP_LEN idle cycles. It also emits training bursts.
// Latency: a start sampled at edge k drives HEAD0 out after edge k+1. All byte outputs are registered one stage after the FSM.
// Backpressure: the source is never stalled. If src_valid is low in a ready slot, IDLE_BYTE is sent and underrun_err is set.
module lvds_frame_tx_ctrl #(
  parameter int unsigned PAYLOAD_LEN = 124,
  parameter int unsigned GAP_LEN     = 4,
  parameter int unsigned TRAIN_LEN   = 16,
  parameter logic [7:0]  HEAD0       = 8'hEE,
  parameter logic [7:0]  HEAD1       = 8'h33,
  parameter logic [7:0]  IDLE_BYTE   = 8'h00,
  parameter logic [7:0]  TRAIN_BYTE  = 8'h55
) (
  input  logic                  clk,
  input  logic                  rst,
  lvds_frame_tx_ctrl_if.slave   bus
);

  localparam logic [2:0] S_IDLE    = 3'd0;
  localparam logic [2:0] S_TRAIN   = 3'd1;
  localparam logic [2:0] S_HDR0    = 3'd2;
  localparam logic [2:0] S_HDR1    = 3'd3;
  localparam logic [2:0] S_PAYLOAD = 3'd4;
  localparam logic [2:0] S_GAP     = 3'd5;

  localparam logic [9:0] PAY_LAST   = 10'(PAYLOAD_LEN - 1);
  localparam logic [9:0] GAP_LAST   = 10'(GAP_LEN - 1);
  localparam logic [9:0] TRAIN_LAST = 10'(TRAIN_LEN - 1);

  logic [2:0] state_q, state_d;
  logic [9:0] cnt_q, cnt_d;
  logic       pending_q, pending_d;
  logic       underrun_q, underrun_d;
  logic [7:0] tx_data_q, tx_data_d;
  logic       tx_en_q, tx_en_d;
  logic       busy_q, busy_d;
  logic       done_q, done_d;
  logic       ur_set, ur_clr;

  // A payload byte is loaded on the next edge exactly when the FSM is in PAYLOAD.
  assign bus.src_ready    = (state_q == S_PAYLOAD);
  assign bus.tx_data      = tx_data_q;
  assign bus.tx_en        = tx_en_q;
  assign bus.busy         = busy_q;
  assign bus.frame_done   = done_q;
  assign bus.underrun_err = underrun_q;

  // Next state, the shared slot counter, and the one-deep pending-frame flag.
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    pending_d = pending_q;
    // Any start seen while busy is queued. Repeats simply re-set the same bit.
    if (bus.start && (state_q != S_IDLE)) pending_d = 1'b1;
    case (state_q)
      S_IDLE: begin
        if (bus.train_req) begin
          // Training wins. A simultaneous start is kept and serviced right after the burst.
          state_d   = S_TRAIN;
          cnt_d     = '0;
          pending_d = bus.start;
        end else if (bus.start) begin
          state_d = S_HDR0;
        end
      end
      S_TRAIN: begin
        if (cnt_q == TRAIN_LAST) begin
          cnt_d = '0;
          if (pending_q || bus.start) begin
            state_d   = S_HDR0;
            pending_d = 1'b0;
          end else begin
            state_d = S_IDLE;
          end
        end else begin
          cnt_d = cnt_q + 10'd1;
        end
      end
      S_HDR0: state_d = S_HDR1;
      S_HDR1: begin
        state_d = S_PAYLOAD;
        cnt_d   = '0;
      end
      S_PAYLOAD: begin
        if (cnt_q == PAY_LAST) begin
          state_d = S_GAP;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + 10'd1;
        end
      end
      S_GAP: begin
        if (cnt_q == GAP_LAST) begin
          cnt_d = '0;
          // A start in the last gap cycle launches back-to-back with exactly GAP_LEN idles.
          if (pending_q || bus.start) begin
            state_d   = S_HDR0;
            pending_d = 1'b0;
          end else begin
            state_d = S_IDLE;
          end
        end else begin
          cnt_d = cnt_q + 10'd1;
        end
      end
      default: begin
        state_d   = S_IDLE;
        cnt_d     = '0;
        pending_d = 1'b0;
      end
    endcase
  end

  // Sticky underrun flag. A set in the same cycle beats a clear from a new start.
  always_comb begin
    ur_set     = (state_q == S_PAYLOAD) && !bus.src_valid;
    ur_clr     = bus.start && ((state_q == S_IDLE) || (state_q == S_GAP));
    underrun_d = underrun_q;
    if (ur_set)      underrun_d = 1'b1;
    else if (ur_clr) underrun_d = 1'b0;
  end

  // Output byte for the slot the FSM is in now. It is registered on the next edge.
  always_comb begin
    tx_data_d = IDLE_BYTE;
    tx_en_d   = 1'b0;
    case (state_q)
      S_TRAIN: begin
        tx_data_d = TRAIN_BYTE;
        tx_en_d   = 1'b1;
      end
      S_HDR0: begin
        tx_data_d = HEAD0;
        tx_en_d   = 1'b1;
      end
      S_HDR1: begin
        tx_data_d = HEAD1;
        tx_en_d   = 1'b1;
      end
      S_PAYLOAD: begin
        tx_data_d = bus.src_valid ? bus.src_data : IDLE_BYTE;
        tx_en_d   = 1'b1;
      end
      default: begin
        tx_data_d = IDLE_BYTE;
        tx_en_d   = 1'b0;
      end
    endcase
    busy_d = (state_q != S_IDLE);
    done_d = (state_q == S_GAP) && (cnt_q == '0);
  end

  // State and output registers. A synchronous reset aborts any frame in flight.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= S_IDLE;
      cnt_q      <= '0;
      pending_q  <= 1'b0;
      underrun_q <= 1'b0;
      tx_data_q  <= IDLE_BYTE;
      tx_en_q    <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      pending_q  <= pending_d;
      underrun_q <= underrun_d;
      tx_data_q  <= tx_data_d;
      tx_en_q    <= tx_en_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
    end
  end

endmodule

// File: tb/tb_lvds_frame_tx_ctrl.sv
// Testbench for lvds_frame_tx_ctrl. It runs directed frame, back-to-back, underrun, training, reset and random-traffic steps.
// A scoreboard queue holds expected payload bytes. The monitor checks headers, lengths, gaps and frame_done pulses.
// The payload source never stalls. Its valid pattern is selected per step.
`timescale 1ns/1ps
module tb_lvds_frame_tx_ctrl;
  localparam int PLEN = 124;
  localparam int GLEN = 4;
  localparam int TLEN = 16;
  localparam logic [7:0] H0    = 8'hEE;
  localparam logic [7:0] H1    = 8'h33;
  localparam logic [7:0] IDLEB = 8'h00;
  localparam logic [7:0] TRB   = 8'h55;

  logic clk = 1'b0;
  logic rst = 1'b1;

  lvds_frame_tx_ctrl_if bus();

  lvds_frame_tx_ctrl #(
    .PAYLOAD_LEN(PLEN), .GAP_LEN(GLEN), .TRAIN_LEN(TLEN),
    .HEAD0(H0), .HEAD1(H1), .IDLE_BYTE(IDLEB), .TRAIN_BYTE(TRB)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // The payload source drives byte value = slot index within the frame.
  // Each ready slot pushes the byte the link is expected to carry.
  logic [7:0] slot = 8'd0;
  bit         drop10    = 1'b0;
  bit         rnd_valid = 1'b0;
  logic [7:0] exp_q[$];

  always @(negedge clk) begin : src
    logic v;
    if (rst) begin
      slot = 8'd0;
      exp_q.delete();
    end
    v = 1'b1;
    if (rnd_valid) v = ($urandom_range(0, 3) != 0);
    if (drop10 && (slot == 8'd10)) v = 1'b0;
    bus.src_valid = v;
    bus.src_data  = slot;
    if (!rst && (bus.src_ready === 1'b1)) begin
      exp_q.push_back(v ? slot : IDLEB);
      slot = (slot == 8'(PLEN - 1)) ? 8'd0 : slot + 8'd1;
    end
  end

  // The monitor splits tx_en activity into training bursts and frames, then checks each one.
  int pos = 0;
  bit in_run = 0, is_train = 0, exp_done = 0, prev_frame = 0;
  int gap_cnt = 0, last_gap = 0, frames = 0, trains = 0, fd_cnt = 0;
  int last_train_end = 0, last_frame_start = 0;

  always @(negedge clk) begin : mon
    if (rst) begin
      in_run = 0; pos = 0; exp_done = 0; prev_frame = 0; gap_cnt = 0;
    end else begin
      chk("frame_done", bus.frame_done, exp_done);
      if (bus.frame_done === 1'b1) fd_cnt++;
      exp_done = 0;
      if (!in_run && (bus.tx_en === 1'b1)) begin
        in_run = 1;
        pos = 0;
        is_train = (bus.tx_data == TRB);
        if (is_train) begin
          trains++;
        end else begin
          last_frame_start = cyc;
          if (prev_frame) begin
            chk("gap_min", gap_cnt >= GLEN, 1);
            last_gap = gap_cnt;
          end
        end
        prev_frame = 0;
      end
      if (in_run) begin
        if (bus.tx_en !== 1'b1) begin
          chk("run_len", pos, is_train ? TLEN : PLEN + 2);
          in_run = 0;
        end else begin
          if (is_train) chk("train_byte", bus.tx_data, TRB);
          else if (pos == 0) chk("hdr0", bus.tx_data, H0);
          else if (pos == 1) chk("hdr1", bus.tx_data, H1);
          else if (exp_q.size() == 0) chk("sb_underflow", 1, 0);
          else chk("payload", bus.tx_data, exp_q.pop_front());
          pos++;
          if (is_train && (pos == TLEN)) begin
            in_run = 0;
            last_train_end = cyc;
          end
          if (!is_train && (pos == PLEN + 2)) begin
            in_run = 0; frames++; exp_done = 1; prev_frame = 1; gap_cnt = 0;
          end
        end
      end else if (bus.tx_en !== 1'b1) begin
        gap_cnt++;
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic wait_idle(input string tag);
    int n;
    n = 0;
    tick();
    tick();
    while ((bus.busy !== 1'b0) && (n < 2000)) begin
      tick();
      n++;
    end
    chk({tag, "_idle_timeout"}, n < 2000, 1);
  endtask

  task automatic pulse_start();
    bus.start = 1'b1;
    tick();
    bus.start = 1'b0;
  endtask

  initial begin : watchdog
    #3000000;
    $display("FAIL watchdog: simulation did not complete in time");
    $fatal(1, "watchdog");
  end

  initial begin : stim
    int f0, t0, d0;
    bus.start     = 1'b0;
    bus.train_req = 1'b0;

    // Reset state
    rst = 1'b1;
    tick();
    tick();
    chk("rst_tx_data", bus.tx_data, IDLEB);
    chk("rst_tx_en", bus.tx_en, 0);
    chk("rst_busy", bus.busy, 0);
    chk("rst_frame_done", bus.frame_done, 0);
    chk("rst_underrun", bus.underrun_err, 0);
    chk("rst_src_ready", bus.src_ready, 0);
    rst = 1'b0;
    tick();

    // Single frame with absolute timing relative to the start edge k
    pulse_start();
    chk("k_tx_en", bus.tx_en, 0);
    tick();
    chk("k1_hdr0", bus.tx_data, H0);
    chk("k1_tx_en", bus.tx_en, 1);
    chk("k1_busy", bus.busy, 1);
    tick();
    chk("k2_hdr1", bus.tx_data, H1);
    chk("k2_src_ready", bus.src_ready, 1);
    for (int i = 0; i < PLEN; i++) begin
      tick();
      chk("pay_seq", bus.tx_data, 8'(i));
    end
    tick();
    chk("k127_done", bus.frame_done, 1);
    chk("k127_tx_en", bus.tx_en, 0);
    chk("k127_busy", bus.busy, 1);
    chk("k127_src_ready", bus.src_ready, 0);
    tick();
    tick();
    tick();
    chk("k130_busy", bus.busy, 1);
    chk("k130_done", bus.frame_done, 0);
    tick();
    chk("k131_busy", bus.busy, 0);

    // Start held for three cycles mid-payload yields one extra frame after exactly GAP_LEN idles
    f0 = frames;
    pulse_start();
    repeat (20) tick();
    bus.start = 1'b1;
    repeat (3) tick();
    bus.start = 1'b0;
    wait_idle("b2b");
    chk("b2b_frames", frames - f0, 2);
    chk("b2b_gap", last_gap, GLEN);

    // Underrun in payload slot 10
    f0 = frames;
    drop10 = 1'b1;
    pulse_start();
    wait_idle("ur");
    drop10 = 1'b0;
    chk("ur_frames", frames - f0, 1);
    chk("ur_sticky", bus.underrun_err, 1);
    pulse_start();
    chk("ur_clear", bus.underrun_err, 0);
    wait_idle("ur2");

    // Training and start together: training first, then the frame on the next cycle
    f0 = frames;
    t0 = trains;
    d0 = fd_cnt;
    bus.train_req = 1'b1;
    bus.start     = 1'b1;
    tick();
    bus.train_req = 1'b0;
    bus.start     = 1'b0;
    wait_idle("train");
    chk("train_count", trains - t0, 1);
    chk("train_frames", frames - f0, 1);
    chk("train_fd", fd_cnt - d0, 1);
    chk("train_seam", last_frame_start - last_train_end, 1);

    // Reset in the middle of a frame
    f0 = frames;
    d0 = fd_cnt;
    pulse_start();
    repeat (53) tick();
    chk("mid_byte50", bus.tx_data, 8'd50);
    rst = 1'b1;
    tick();
    chk("mid_rst_tx_en", bus.tx_en, 0);
    chk("mid_rst_busy", bus.busy, 0);
    chk("mid_rst_ready", bus.src_ready, 0);
    rst = 1'b0;
    repeat (6) tick();
    chk("mid_no_done", fd_cnt - d0, 0);
    chk("mid_no_frame", frames - f0, 0);
    pulse_start();
    wait_idle("mid");
    chk("mid_next_frame", frames - f0, 1);

    // Random start and src_valid traffic
    f0 = frames;
    rnd_valid = 1'b1;
    for (int i = 0; i < 10000; i++) begin
      bus.start = ($urandom_range(0, 39) == 0);
      tick();
    end
    bus.start = 1'b0;
    wait_idle("rnd");
    rnd_valid = 1'b0;
    chk("rnd_frames", (frames - f0) > 20, 1);
    chk("sb_empty", exp_q.size(), 0);
    chk("done_vs_frames", fd_cnt, frames);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
